serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised digit-serial adder/subtractor, the multi-cycle successor to the combinational 4-bit adders. It processes a W-bit operand pair D bits per clock, LSB digit first, and reports sum, carry-out and signed overflow with a start/done handshake. It trades latency for area in wide datapaths where a full-width carry chain is not wanted.

## Interface
- W, default 16: operand and sum width; must be a positive multiple of D.
- D, default 4: digit width processed per cycle; N = W/D cycles per operation.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = add (a + b + cin), 1 = subtract (a - b - cin); sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- cin  in  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy  out  1  high while digits are being processed (state RUN).
- done  out  1  one-cycle pulse: result registers updated on this cycle.
- s  out  W  result, registered; holds until the next completion.
- co  out  1  raw carry-out of the MSB; for sub, 1 = no borrow, 0 = borrow.
- ovf  out  1  signed overflow: carry into MSB xor carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset: state IDLE; busy=0, done=0, s=0, co=0, ovf=0; digit counter 0.
- IDLE: start=1 at an edge latches a; latches b, or ~b when sub=1; latches carry = sub ? ~cin : cin. The FSM then enters RUN with counter 0. start=0 keeps IDLE.
- RUN: each edge adds digit[counter] of A and B' plus the carry. The D-bit sum goes into the internal result shift register, the carry updates, and the counter increments. On the edge that processes digit N-1:
  - s is loaded with the full result.
  - co is loaded with the final carry.
  - ovf is loaded with the carry into bit W-1 xor the final carry.
  - The FSM enters DONE.
- start, sub, a, b and cin are ignored in RUN; operands may change freely there.
- DONE: done=1 for exactly one cycle. start=1 at this edge begins a new operation as from IDLE (back-to-back). Otherwise the FSM returns to IDLE.
- s, co and ovf change only on the completion edge or on reset. They never show partial results.
- Arithmetic is modulo 2^W. The subtract form is a + ~b + ~cin.
- Reset in any state aborts the operation: no done pulse, and all outputs return to reset values on that edge.
- D = W (N = 1) is legal: RUN lasts one cycle.

## Timing
- Start accepted at edge 0. busy=1 after edges 0..N-1 (N cycles). At edge N: busy=0, done=1, and s/co/ovf are valid.
- Latency from the start edge to a valid result: N edges. Throughput: one operation per N+1 cycles (N back-to-back via DONE).
- done and busy are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles during RUN -> busy=0, done=0, s=0x0000, co=0, ovf=0; no done pulse follows.
- Add, W=16, D=4: a=0x1234, b=0x0FFF, cin=0, sub=0 -> busy for 4 cycles, then done with s=0x2233, co=0, ovf=0, exactly 4 edges after the start edge.
- Carry and overflow:
  - a=0xFFFF, b=0x0001 -> s=0x0000, co=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, co=0, ovf=0.
  - Same with cin=1 -> s=0xFFFD.
  - a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
- Handshake:
  - start held high and operands changed during RUN -> result reflects only the operands latched at start.
  - start=1 on the DONE cycle -> second result done 4 edges later.
  - s holds the first result throughout the second RUN.
- Parameter sweep: W=8, D=8 and W=12, D=3. Random operands against a reference a±b±cin model -> every result matches, with latency N.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes a W-bit operand pair D bits per clock,
// LSB digit first, with a start/done handshake and registered sum, carry-out and overflow.
module serial_adder #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] s,
   output logic         co,
   output logic         ovf
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           carry_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   s_q;
   logic           co_q;
   logic           ovf_q;

   logic [D-1:0]   a_dig_s;
   logic [D-1:0]   b_dig_s;
   logic [D:0]     digit_sum_s;
   logic           carry_msb_s;
   logic [W-1:0]   result_d;

   // Current digit of both latched operands summed with the running carry
   always_comb begin
      a_dig_s     = a_q[cnt_q*D +: D];
      b_dig_s     = b_q[cnt_q*D +: D];
      digit_sum_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{D{1'b0}}, carry_q};
      // Carry into a bit is recovered from its sum bit and its two operand bits.
      carry_msb_s = digit_sum_s[D-1] ^ a_dig_s[D-1] ^ b_dig_s[D-1];
   end

   // Partial result: each new digit enters at the top and settles in place after N digits
   generate
      if (N == 1) begin : g_single
         assign result_d = digit_sum_s[D-1:0];
      end else begin : g_multi
         logic [W-D-1:0] res_q;

         // Shift register holding the digits produced so far
         always_ff @(posedge clk) begin
            if (rst) begin
               res_q <= '0;
            end else if (state_q == RUN) begin
               res_q <= result_d[W-1:D];
            end else begin
               res_q <= res_q;
            end
         end

         assign result_d = {digit_sum_s[D-1:0], res_q};
      end
   endgenerate

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         s_q     <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? ~cin : cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               carry_q <= digit_sum_s[D];
               if (cnt_q == LAST) begin
                  s_q     <= result_d;
                  co_q    <= digit_sum_s[D];
                  ovf_q   <= carry_msb_s ^ digit_sum_s[D];
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and seeded-random bench for serial_adder at (W,D) = (16,4), (8,8) and (12,3).
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  start_v = 3'b000;
   logic [2:0]  sub_v   = 3'b000;
   logic [2:0]  cin_v   = 3'b000;
   logic [15:0] a16 = 16'h0, b16 = 16'h0;
   logic [7:0]  a8  = 8'h0,  b8  = 8'h0;
   logic [11:0] a12 = 12'h0, b12 = 12'h0;
   logic [2:0]  busy_v, done_v, co_v, ovf_v;
   logic [15:0] s16;
   logic [7:0]  s8;
   logic [11:0] s12;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   serial_adder #(.W(16), .D(4)) u16 (
      .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]), .a(a16), .b(b16), .cin(cin_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .s(s16), .co(co_v[0]), .ovf(ovf_v[0]));
   serial_adder #(.W(8), .D(8)) u8 (
      .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]), .a(a8), .b(b8), .cin(cin_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .s(s8), .co(co_v[1]), .ovf(ovf_v[1]));
   serial_adder #(.W(12), .D(3)) u12 (
      .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]), .a(a12), .b(b12), .cin(cin_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .s(s12), .co(co_v[2]), .ovf(ovf_v[2]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int inst, input logic st, input logic sb,
                        input logic [15:0] av, input logic [15:0] bv, input logic c);
      start_v[inst] = st;
      sub_v[inst]   = sb;
      cin_v[inst]   = c;
      case (inst)
         0:       begin a16 = av;        b16 = bv;        end
         1:       begin a8  = av[7:0];   b8  = bv[7:0];   end
         default: begin a12 = av[11:0];  b12 = bv[11:0];  end
      endcase
   endtask

   function automatic logic [15:0] get_s(input int inst);
      case (inst)
         0:       return s16;
         1:       return {8'h00, s8};
         default: return {4'h0, s12};
      endcase
   endfunction

   function automatic int n_of(input int inst);
      return (inst == 1) ? 1 : 4;
   endfunction

   // Full-width reference: {ovf, co, s} of a + b' + c' modulo 2^w
   function automatic logic [17:0] ref_op(input int inst, input logic sb,
                                          input logic [15:0] av, input logic [15:0] bv, input logic c);
      int w;
      logic [15:0] mask, aa, bb, ss;
      logic [16:0] full;
      logic cc, ov;
      w    = (inst == 0) ? 16 : (inst == 1) ? 8 : 12;
      mask = 16'((17'd1 << w) - 17'd1);
      aa   = av & mask;
      bb   = (sb ? ~bv : bv) & mask;
      full = {1'b0, aa} + {1'b0, bb} + {16'h0, (sb ? ~c : c)};
      cc   = full[w];
      ss   = full[15:0] & mask;
      ov   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
      return {ov, cc, ss};
   endfunction

   task automatic run_op(input string tag, input int inst, input logic sb,
                         input logic [15:0] av, input logic [15:0] bv, input logic c,
                         input logic [15:0] exp_s, input logic exp_co, input logic exp_ovf);
      int lat;
      int n;
      logic got;
      n   = n_of(inst);
      lat = 0;
      got = 1'b0;
      @(negedge clk);
      drive(inst, 1'b1, sb, av, bv, c);
      @(posedge clk);
      #1;
      drive(inst, 1'b0, ~sb, ~av, ~bv, ~c);
      check_val({tag, "_busy0"}, 32'(busy_v[inst]), 32'd1);
      while (!got && lat < n + 3) begin
         @(posedge clk);
         #1;
         lat++;
         if (done_v[inst]) got = 1'b1;
         else check_val({tag, "_busy"}, 32'(busy_v[inst]), 32'd1);
      end
      check_val({tag, "_lat"}, 32'(lat), 32'(n));
      check_val({tag, "_s"}, 32'(get_s(inst)), 32'(exp_s));
      check_val({tag, "_co"}, 32'(co_v[inst]), 32'(exp_co));
      check_val({tag, "_ovf"}, 32'(ovf_v[inst]), 32'(exp_ovf));
      check_val({tag, "_busyd"}, 32'(busy_v[inst]), 32'd0);
   endtask

   initial begin
      logic [17:0] r;
      logic [15:0] ra, rb;
      logic rsb, rc;
      int dcnt;

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val("rst_busy", 32'(busy_v[i]), 32'd0);
         check_val("rst_done", 32'(done_v[i]), 32'd0);
         check_val("rst_s", 32'(get_s(i)), 32'd0);
         check_val("rst_co", 32'(co_v[i]), 32'd0);
         check_val("rst_ovf", 32'(ovf_v[i]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      run_op("add",   0, 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      run_op("carry", 0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("ovf",   0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub",   0, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("subc",  0, 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b0);
      run_op("subov", 0, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      run_op("addc",  0, 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

      // start held high, operands changed during RUN, then back-to-back via DONE
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 1'b0, 16'h0100, 16'h0001, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (i < 4) check_val("hold_busy", 32'(busy_v[0]), 32'd1);
      end
      check_val("hold_done", 32'(done_v[0]), 32'd1);
      check_val("hold_s", 32'(s16), 32'h3333);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b0);
      check_val("b2b_busy", 32'(busy_v[0]), 32'd1);
      check_val("b2b_done0", 32'(done_v[0]), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         if (i < 4) begin
            check_val("b2b_shold", 32'(s16), 32'h3333);
         end
         @(posedge clk);
         #1;
      end
      check_val("b2b_done", 32'(done_v[0]), 32'd1);
      check_val("b2b_s", 32'(s16), 32'h0101);

      // reset during RUN aborts the operation
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("ab_busy", 32'(busy_v[0]), 32'd0);
      check_val("ab_done", 32'(done_v[0]), 32'd0);
      check_val("ab_s", 32'(s16), 32'h0000);
      check_val("ab_co", 32'(co_v[0]), 32'd0);
      check_val("ab_ovf", 32'(ovf_v[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (done_v[0] || busy_v[0]) dcnt++;
      end
      check_val("ab_nodone", 32'(dcnt), 32'd0);

      // boundary vectors for the other widths
      run_op("w8_ovf",  1, 1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1);
      run_op("w8_sub",  1, 1'b1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b1, 1'b1);
      run_op("w12_car", 2, 1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("w12_sub", 2, 1'b1, 16'h0005, 16'h0007, 1'b1, 16'h0FFD, 1'b0, 1'b0);

      for (int inst = 0; inst < 3; inst++) begin
         for (int k = 0; k < 8; k++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rsb = 1'($urandom);
            rc  = 1'($urandom);
            r   = ref_op(inst, rsb, ra, rb, rc);
            run_op("rnd", inst, rsb, ra, rb, rc, r[15:0], r[16], r[17]);
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
